// File: rtl/bp_pkg.sv
// Shared types, sizes and counter helper for the fetch-side branch predictor.
package bp_pkg;

  localparam int unsigned PC_W             = 32;
  localparam int unsigned IDX_BITS         = 6;
  localparam int unsigned ENTRIES          = 1 << IDX_BITS;
  localparam int unsigned TAG_W            = 12;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [1:0]       ctr;
  } entry_t;

  typedef enum logic {
    BP_IDLE,
    BP_FLUSH
  } bp_state_e;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

  function automatic logic [IDX_BITS-1:0] pc_idx(input logic [PC_W-1:0] pc);
    return pc[IDX_BITS+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc);
    return pc[IDX_BITS+2 +: TAG_W];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX resolution and redirect/flush signals between pipeline and predictor.
interface branch_predictor_if;
  import bp_pkg::*;

  logic [PC_W-1:0] if_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

  logic            ex_valid;
  logic            ex_is_jump;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;

  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     stat_br;
  logic [31:0]     stat_miss;

  modport master (
    output if_pc, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, flush,
           stat_br, stat_miss
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, flush,
           stat_br, stat_miss
  );

endinterface

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: two async read ports, one sync write port, async clear.
module bp_table
  import bp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx_a,
  output entry_t              rd_entry_a,
  input  logic [IDX_BITS-1:0] rd_idx_b,
  output entry_t              rd_entry_b,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  entry_t              wr_entry
);

  localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

  entry_t mem [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem[i] <= RESET_ENTRY;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  // Reads see pre-edge contents, so a same-cycle write is not bypassed.
  assign rd_entry_a = mem[rd_idx_a];
  assign rd_entry_b = mem[rd_idx_b];

endmodule

// File: rtl/branch_predictor.sv
// BTB branch predictor with 2-bit counters, mispredict redirect and timed flush.
// Optional BP_STATS_EN builds resolved/mispredict counters; otherwise they read 0.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
)(
  input  logic clk,
  input  logic reset_n,
  branch_predictor_if.slave bus
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  entry_t          look_e;
  entry_t          ex_e;
  entry_t          wr_e;
  logic            look_hit;
  logic            ex_hit;
  logic            accept;
  logic            miss;
  logic [PC_W-1:0] redirect_next;

  bp_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;

  bp_table u_table (
    .clk        (clk),
    .rst_n      (reset_n),
    .rd_idx_a   (pc_idx(bus.if_pc)),
    .rd_entry_a (look_e),
    .rd_idx_b   (pc_idx(bus.ex_pc)),
    .rd_entry_b (ex_e),
    .wr_en      (accept),
    .wr_idx     (pc_idx(bus.ex_pc)),
    .wr_entry   (wr_e)
  );

  // Fetch-side lookup.
  assign look_hit        = look_e.valid && (look_e.tag == pc_tag(bus.if_pc));
  assign bus.pred_taken  = look_hit & look_e.ctr[1];
  assign bus.pred_target = look_hit ? look_e.target : bus.if_pc + PC_W'(4);

  // EX-side resolution against the carried prediction.
  assign ex_hit = ex_e.valid && (ex_e.tag == pc_tag(bus.ex_pc));
  assign accept = bus.ex_valid && (state == BP_IDLE);
  assign miss   = (bus.ex_taken != bus.ex_pred_taken) ||
                  (bus.ex_taken && bus.ex_pred_taken && (bus.ex_target != bus.ex_pred_target));
  assign redirect_next = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_W'(4);

  always_comb begin
    wr_e        = ex_e;
    wr_e.valid  = ex_e.valid | bus.ex_taken;
    wr_e.tag    = pc_tag(bus.ex_pc);
    wr_e.target = bus.ex_target;
    if (bus.ex_is_jump) begin
      wr_e.ctr = CTR_ST;
    end else if (ex_hit) begin
      wr_e.ctr = ctr_next(ex_e.ctr, bus.ex_taken);
    end else begin
      wr_e.ctr = bus.ex_taken ? CTR_WT : CTR_WNT;
    end
  end

  // Redirect/flush controller; EX results are wrong-path while flushing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BP_IDLE;
      cnt         <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
    end else begin
      mispredict <= 1'b0;
      case (state)
        BP_IDLE: begin
          if (accept && miss) begin
            state       <= BP_FLUSH;
            mispredict  <= 1'b1;
            redirect_pc <= redirect_next;
            flush       <= 1'b1;
            cnt         <= CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            flush <= 1'b0;
          end
        end
        BP_FLUSH: begin
          if (cnt == '0) begin
            state <= BP_IDLE;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= BP_IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mispredict  = mispredict;
  assign bus.redirect_pc = redirect_pc;
  assign bus.flush       = flush;

`ifdef BP_STATS_EN
  logic [31:0] stat_br;
  logic [31:0] stat_miss;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_br   <= '0;
      stat_miss <= '0;
    end else if (accept) begin
      stat_br <= stat_br + 32'd1;
      if (miss) begin
        stat_miss <= stat_miss + 32'd1;
      end
    end
  end

  assign bus.stat_br   = stat_br;
  assign bus.stat_miss = stat_miss;
`else
  assign bus.stat_br   = '0;
  assign bus.stat_miss = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: driver pushes model-predicted outputs per cycle, monitor compares.
module tb_branch_predictor;
  import bp_pkg::*;

  localparam int FLUSH_N = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  branch_predictor_if bus ();

  branch_predictor #(.FLUSH_CYCLES(FLUSH_N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
    logic        fl;
    logic [31:0] sbr;
    logic [31:0] smiss;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: plain arrays indexed by BTB slot.
  bit          m_valid [64];
  int          m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  bit          m_mp;
  logic [31:0] m_rpc;
  int          m_flush_left;
  logic [31:0] m_sbr, m_smiss;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int tagof(input logic [31:0] pc);
    return int'((pc >> 8) % 4096);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_mp = 0; m_rpc = 0; m_flush_left = 0; m_sbr = 0; m_smiss = 0;
  endtask

  function automatic void m_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
    int s = slot(pc);
    if (m_valid[s] && m_tag[s] == tagof(pc)) begin
      pt = (m_ctr[s] >= 2); tgt = m_tgt[s];
    end else begin
      pt = 0; tgt = pc + 32'd4;
    end
  endfunction

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_step();
    int  s;
    bit  hit, miss;
    if (m_flush_left > 0) begin
      m_mp = 0;
      m_flush_left--;
    end else begin
      m_mp = 0;
      if (bus.ex_valid) begin
        s   = slot(bus.ex_pc);
        hit = m_valid[s] && (m_tag[s] == tagof(bus.ex_pc));
        if (bus.ex_is_jump) m_ctr[s] = 3;
        else if (hit) m_ctr[s] = bus.ex_taken ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                                              : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
        else m_ctr[s] = bus.ex_taken ? 2 : 1;
        m_tag[s] = tagof(bus.ex_pc);
        m_tgt[s] = bus.ex_target;
        if (bus.ex_taken) m_valid[s] = 1;
        miss = (bus.ex_taken != bus.ex_pred_taken) ||
               (bus.ex_taken && bus.ex_pred_taken && bus.ex_target != bus.ex_pred_target);
        m_sbr = m_sbr + 1;
        if (miss) begin
          m_smiss      = m_smiss + 1;
          m_mp         = 1;
          m_rpc        = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
          m_flush_left = FLUSH_N;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    m_lookup(bus.if_pc, e.pt, e.ptgt);
    e.mp = m_mp; e.rpc = m_rpc; e.fl = (m_flush_left > 0);
`ifdef BP_STATS_EN
    e.sbr = m_sbr; e.smiss = m_smiss;
`else
    e.sbr = 0; e.smiss = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [31:0] pc, input logic ev, input logic jmp,
                       input logic [31:0] expc, input logic tk, input logic [31:0] tgt,
                       input logic ept, input logic [31:0] eptgt);
    @(posedge clk);
    #1;
    bus.if_pc = pc; bus.ex_valid = ev; bus.ex_is_jump = jmp; bus.ex_pc = expc;
    bus.ex_taken = tk; bus.ex_target = tgt; bus.ex_pred_taken = ept; bus.ex_pred_target = eptgt;
    push_expected();
    model_step();
  endtask

  task automatic idle(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) cycle(pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bus.ex_valid = 1'b0;
    model_reset();
    push_expected();
    #2;
    reset_n = 1'b1;
    model_step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation once per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pred_taken",  32'(bus.pred_taken), 32'(e.pt));
      chk("pred_target", bus.pred_target, e.ptgt);
      chk("mispredict",  32'(bus.mispredict), 32'(e.mp));
      if (e.mp) chk("redirect_pc", bus.redirect_pc, e.rpc);
      chk("flush",       32'(bus.flush), 32'(e.fl));
      chk("stat_br",     bus.stat_br, e.sbr);
      chk("stat_miss",   bus.stat_miss, e.smiss);
    end
  end

  logic [31:0] pc_a, pc_b, tgt_r;
  logic        ept_r;
  logic [31:0] eptgt_r;

  function automatic logic [31:0] rand_pc();
    return ($urandom & 32'hFFF0_0000) | (32'($urandom_range(1, 2)) << 8) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    bus.if_pc = 0; bus.ex_valid = 0; bus.ex_is_jump = 0; bus.ex_pc = 0;
    bus.ex_taken = 0; bus.ex_target = 0; bus.ex_pred_taken = 0; bus.ex_pred_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // Reset lookup, then taken branch predicted not-taken.
    cycle(32'h100, 0, 0, 0, 0, 0, 0, 0);
    cycle(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    idle(32'h100, 4);
    // Three correctly-predicted not-taken resolutions saturate the counter at 0.
    for (int i = 0; i < 3; i++) cycle(32'h100, 1, 0, 32'h100, 0, 32'h104, 0, 32'h104);
    idle(32'h100, 2);
    // Miss, then a wrong-path EX miss during the flush window.
    cycle(32'h100, 1, 0, 32'h300, 1, 32'h400, 0, 32'h304);
    cycle(32'h100, 1, 0, 32'h100, 1, 32'h999, 0, 32'h104);
    idle(32'h100, 3);
    // Wrong predicted target.
    cycle(32'h500, 1, 0, 32'h500, 1, 32'h240, 1, 32'h200);
    idle(32'h500, 3);
    // Jump at top of address space: fall-through wraps to 0.
    cycle(32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10);
    idle(32'hFFFF_FFFC, 3);
    // Reset mid-flush clears flush and the table.
    cycle(32'h100, 1, 0, 32'h600, 1, 32'h700, 0, 32'h604);
    do_reset();
    idle(32'h100, 2);
    idle(32'h500, 1);

    // Randomized traffic over a small aliasing PC pool.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        pc_a  = rand_pc();
        pc_b  = rand_pc();
        tgt_r = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
        if ($urandom_range(0, 9) < 7) begin
          m_lookup(pc_b, ept_r, eptgt_r);
        end else begin
          ept_r   = 1'($urandom);
          eptgt_r = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
        end
        cycle(pc_a, ($urandom_range(0, 9) < 6), ($urandom_range(0, 4) == 0), pc_b,
              1'($urandom), tgt_r, ept_r, eptgt_r);
      end
    end

    idle(32'h0, 2);
    repeat (2) @(posedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
